// File: rtl/uart_pkg.sv
// Shared UART definitions for the program loader slice.
//   uart_reg_e     : AXI4-lite register offsets of the UART block
//   loader_state_e : program loader FSM states
//   shift_in_byte  : big-endian byte accumulator (first byte ends up in [31:24])
package uart_pkg;

  typedef enum logic [3:0] {
    RX_FIFO  = 4'h0,
    TX_FIFO  = 4'h4,
    STAT_REG = 4'h8,
    CTRL_REG = 4'hC
  } uart_reg_e;

  typedef enum logic [2:0] {
    IDLE,
    STAT_AR,
    STAT_R,
    FIFO_AR,
    FIFO_R,
    WRITE,
    DONE,
    ERR
  } loader_state_e;

  localparam int STAT_RX_VALID_BIT = 0;

  function automatic logic [31:0] shift_in_byte(input logic [31:0] acc, input logic [7:0] b);
    return {acc[23:0], b};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// AXI4-lite read channel between the program loader and the UART.
//   master : loader side (drives araddr/arvalid/rready)
//   slave  : UART side   (drives arready/rdata/rresp/rvalid)
interface prog_loader_if;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/uart_axil_read.sv
// Single-beat AXI4-lite read master.
//   clk, rstn : clock, synchronous active-low reset
//   en        : hold high for the whole read; dropping it abandons the read
//   addr      : register to read, presented on araddr while en is high
//   axi       : read channel (master modport)
//   data      : read data, valid when done=1
//   done      : R handshake happens this cycle
//   resp_err  : R handshake with a non-OKAY response
// Address phase and data phase are exclusive, so arvalid and rready are
// never high together and at most one read is outstanding.
module uart_axil_read
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  uart_reg_e         addr,
  prog_loader_if.master     axi,
  output logic [31:0]       data,
  output logic              done,
  output logic              resp_err
);

  logic data_ph;
  logic rready_i;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_ph <= 1'b0;
    end else if (!en) begin
      data_ph <= 1'b0;
    end else if (!data_ph && axi.arready) begin
      data_ph <= 1'b1;
    end else if (data_ph && axi.rvalid) begin
      data_ph <= 1'b0;
    end
  end

  assign rready_i    = en & data_ph;
  assign axi.araddr  = addr;
  assign axi.arvalid = en & ~data_ph;
  assign axi.rready  = rready_i;

  assign done     = axi.rvalid & rready_i;
  assign data     = axi.rdata;
  assign resp_err = done & (axi.rresp != 2'b00);

endmodule

// File: rtl/prog_loader.sv
// Program loader: pulls a length-prefixed big-endian byte stream out of the
// UART RX FIFO and writes it word by word into the instruction BRAM.
//   clk, rstn   : clock, synchronous active-low reset
//   start       : begin a load (ignored while busy)
//   uart_axi    : AXI4-lite read master towards the UART
//   inst_addra  : BRAM byte address {word_count, 2'b00}
//   inst_dina   : BRAM write data
//   inst_wea    : BRAM byte enables, 4'hF for one cycle per word
//   busy        : load in progress
//   done / err  : load finished / aborted, held until next start or reset
//   word_count  : words written so far
//
// state   | meaning
// IDLE    | waiting for start after reset
// STAT_AR | address phase of a STAT_REG poll
// STAT_R  | data phase of a STAT_REG poll, bit0 says a byte is waiting
// FIFO_AR | address phase of an RX_FIFO read
// FIFO_R  | data phase of an RX_FIFO read, byte taken from rdata[7:0]
// WRITE   | one-cycle BRAM write of the assembled word
// DONE    | all N words written (or N=0)
// ERR     | bad response or N larger than the BRAM
module prog_loader
  import uart_pkg::*;
#(
  parameter int MAX_WORDS = 16384
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  prog_loader_if.master     uart_axi,
  output logic [31:0]       inst_addra,
  output logic [31:0]       inst_dina,
  output logic [3:0]        inst_wea,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [29:0]       word_count
);

  // Counts header plus payload bytes; sized so 4*MAX_WORDS+4 never wraps.
  localparam int BCNT_W = $clog2(4 * MAX_WORDS + 5);

  loader_state_e     state, state_nxt;
  logic [BCNT_W-1:0] byte_cnt;
  logic [31:0]       header;
  logic [31:0]       word_q;
  logic [29:0]       wc_q;

  logic              rd_en;
  uart_reg_e         rd_addr;
  logic [31:0]       rd_data;
  logic              rd_done;
  logic              rd_err;
  logic              rd_data_unused;

  logic              idle_like;
  logic              in_header;
  logic              byte_take;
  logic [7:0]        rx_byte;
  logic [31:0]       hdr_full;

  uart_axil_read u_rd (
    .clk      (clk),
    .rstn     (rstn),
    .en       (rd_en),
    .addr     (rd_addr),
    .axi      (uart_axi),
    .data     (rd_data),
    .done     (rd_done),
    .resp_err (rd_err)
  );

  // Read enable/address come straight from the state so the next-state logic
  // has no combinational path back through the read master.
  assign rd_en   = (state == STAT_AR) || (state == STAT_R) ||
                   (state == FIFO_AR) || (state == FIFO_R);
  assign rd_addr = ((state == FIFO_AR) || (state == FIFO_R)) ? RX_FIFO : STAT_REG;

  assign idle_like      = (state == IDLE) || (state == DONE) || (state == ERR);
  assign in_header      = (byte_cnt < BCNT_W'(4));
  assign rx_byte        = rd_data[7:0];
  assign hdr_full       = shift_in_byte(header, rx_byte);
  assign byte_take      = (state == FIFO_R) && rd_done && !rd_err;
  assign rd_data_unused = ^rd_data[31:8];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_nxt = STAT_AR;
      end
      STAT_AR: begin
        if (uart_axi.arready) state_nxt = STAT_R;
      end
      STAT_R: begin
        if (rd_done) begin
          if (rd_err)                          state_nxt = ERR;
          else if (rd_data[STAT_RX_VALID_BIT]) state_nxt = FIFO_AR;
          else                                 state_nxt = STAT_AR;
        end
      end
      FIFO_AR: begin
        if (uart_axi.arready) state_nxt = FIFO_R;
      end
      FIFO_R: begin
        if (rd_done) begin
          if (rd_err) begin
            state_nxt = ERR;
          end else if (in_header) begin
            if (byte_cnt[1:0] != 2'd3)         state_nxt = STAT_AR;
            else if (hdr_full == 32'd0)        state_nxt = DONE;
            else if (hdr_full > 32'(MAX_WORDS)) state_nxt = ERR;
            else                               state_nxt = STAT_AR;
          end else if (byte_cnt[1:0] == 2'd3) begin
            state_nxt = WRITE;
          end else begin
            state_nxt = STAT_AR;
          end
        end
      end
      WRITE: begin
        if ({2'b00, wc_q + 30'd1} == header) state_nxt = DONE;
        else                                 state_nxt = STAT_AR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      byte_cnt <= '0;
      header   <= '0;
      word_q   <= '0;
      wc_q     <= '0;
    end else begin
      state <= state_nxt;
      if (idle_like && start) begin
        byte_cnt <= '0;
        header   <= '0;
        wc_q     <= '0;
      end
      if (byte_take) begin
        byte_cnt <= byte_cnt + BCNT_W'(1);
        if (in_header) header <= hdr_full;
        else           word_q <= shift_in_byte(word_q, rx_byte);
      end
      if (state == WRITE) wc_q <= wc_q + 30'd1;
    end
  end

  assign inst_wea   = (state == WRITE) ? 4'hF : 4'h0;
  assign inst_addra = {wc_q, 2'b00};
  assign inst_dina  = word_q;
  assign word_count = wc_q;
  assign busy       = !idle_like;
  assign done       = (state == DONE);
  assign err        = (state == ERR);

endmodule
